// File: rtl/dc_trigger_ff_pkg.sv
// Shared types for the dynamic D trigger: next-value select decode.
package dc_trigger_ff_pkg;

    // Which source feeds the master latch ahead of the next rising edge
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_SET  = 2'd2,
        SEL_CLR  = 2'd3
    } sel_e;

    // Clear dominates set (r over s), set dominates load, load over hold
    function automatic sel_e sel_decode(input logic sclr, input logic sset, input logic en);
        sel_e s;
        if (sclr)      s = SEL_CLR;
        else if (sset) s = SEL_SET;
        else if (en)   s = SEL_LOAD;
        else           s = SEL_HOLD;
        return s;
    endfunction

endpackage

// File: rtl/dc_latch.sv
// Level-sensitive D latch, transparent while g is high, async active-low reset.
module dc_latch #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             g,
    input  logic             r_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset dominates; otherwise follow d while the gate is open
    always_latch begin
        if (!r_n)
            q <= RST_VAL;
        else if (g)
            q <= d;
    end

endmodule

// File: rtl/dc_trigger_ff.sv
// Rising-edge D trigger built as a master-slave latch pair with
// async reset and synchronous clear/set/enable.
module dc_trigger_ff
    import dc_trigger_ff_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             c,
    input  logic             r_n,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             sclr,
    input  logic             sset,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq
);

    sel_e             sel;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] mst_q;
    logic             c_n;

    assign c_n = ~c;

    // Next-value mux ahead of the master; hold recirculates the slave output
    always_comb begin
        nxt = q;
        sel = sel_decode(sclr, sset, en);
        unique case (sel)
            SEL_CLR:  nxt = '0;
            SEL_SET:  nxt = '1;
            SEL_LOAD: nxt = d;
            default:  nxt = q;
        endcase
    end

    // Master: open while c is low, freezes the mux value at the rising edge
    dc_latch #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_master (
        .g   (c_n),
        .r_n (r_n),
        .d   (nxt),
        .q   (mst_q)
    );

    // Slave: open while c is high, so q only moves on the rising edge
    dc_latch #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_slave (
        .g   (c),
        .r_n (r_n),
        .d   (mst_q),
        .q   (q)
    );

    assign nq = ~q;

endmodule

// File: tb/tb_dc_trigger_ff.sv
// Self-checking bench: a 1-bit and an 8-bit (RST_VAL=A5) trigger driven
// side by side from step tables; expectations go through a scoreboard queue.
module tb_dc_trigger_ff;

    logic       c    = 1'b0;
    logic       r_n  = 1'b0;
    logic       en   = 1'b0;
    logic       sclr = 1'b0;
    logic       sset = 1'b0;
    logic       d1   = 1'b0;
    logic [7:0] d8   = 8'h00;
    logic       q1, nq1;
    logic [7:0] q8, nq8;

    int errors = 0;
    int checks = 0;

    localparam int A_NONE = 0, A_RISE = 1, A_FALL = 2, A_RST = 3, A_REL = 4;

    typedef struct {
        int         act;
        logic       d1;
        logic [7:0] d8;
        logic       en, sclr, sset;
        logic       e1;
        logic [7:0] e8;
    } step_t;

    typedef struct {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    exp_t sb[$];

    dc_trigger_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_dut1 (
        .c(c), .r_n(r_n), .d(d1), .en(en), .sclr(sclr), .sset(sset), .q(q1), .nq(nq1)
    );

    dc_trigger_ff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
        .c(c), .r_n(r_n), .d(d8), .en(en), .sclr(sclr), .sset(sset), .q(q8), .nq(nq8)
    );

    // Apply one step: set data/controls, perform the clock/reset action, settle.
    task automatic drive(input step_t s);
        exp_t e;
        d1 = s.d1; d8 = s.d8; en = s.en; sclr = s.sclr; sset = s.sset;
        e.q1 = s.e1; e.q8 = s.e8;
        sb.push_back(e);
        #2;
        case (s.act)
            A_RISE:  c = 1'b1;
            A_FALL:  c = 1'b0;
            A_RST:   r_n = 1'b0;
            A_REL:   r_n = 1'b1;
            default: ;
        endcase
        #1;
    endtask

    task automatic test_reset();
        step_t t[7] = '{
            '{A_RST,  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_RISE, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_FALL, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_RISE, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_FALL, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_REL,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_RISE, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C}
        };
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (q1 !== e.q1 || nq1 !== ~e.q1 || q8 !== e.q8 || nq8 !== ~e.q8) begin
                errors++;
                $display("FAIL reset[%0d]: q1=%b nq1=%b q8=%h nq8=%h, required q1=%b q8=%h",
                         i, q1, nq1, q8, nq8, e.q1, e.q8);
            end
        end
    endtask

    task automatic test_edge_capture();
        step_t t[6] = '{
            '{A_FALL, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C},
            '{A_NONE, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C},
            '{A_RISE, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81},
            '{A_NONE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81},
            '{A_FALL, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81},
            '{A_RISE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}
        };
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (q1 !== e.q1 || nq1 !== ~e.q1 || q8 !== e.q8 || nq8 !== ~e.q8) begin
                errors++;
                $display("FAIL edge_capture[%0d]: q1=%b nq1=%b q8=%h nq8=%h, required q1=%b q8=%h",
                         i, q1, nq1, q8, nq8, e.q1, e.q8);
            end
        end
    endtask

    task automatic test_enable_hold();
        step_t t[10] = '{
            '{A_FALL, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
            '{A_RISE, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_FALL, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_RISE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_FALL, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_RISE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_FALL, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_RISE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_FALL, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF},
            '{A_RISE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}
        };
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (q1 !== e.q1 || nq1 !== ~e.q1 || q8 !== e.q8 || nq8 !== ~e.q8) begin
                errors++;
                $display("FAIL enable_hold[%0d]: q1=%b nq1=%b q8=%h nq8=%h, required q1=%b q8=%h",
                         i, q1, nq1, q8, nq8, e.q1, e.q8);
            end
        end
    endtask

    task automatic test_set_clear();
        step_t t[8] = '{
            '{A_FALL, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
            '{A_RISE, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
            '{A_FALL, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
            '{A_RISE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF},
            '{A_FALL, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF},
            '{A_RISE, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00},
            '{A_FALL, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
            '{A_RISE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF}
        };
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (q1 !== e.q1 || nq1 !== ~e.q1 || q8 !== e.q8 || nq8 !== ~e.q8) begin
                errors++;
                $display("FAIL set_clear[%0d]: q1=%b nq1=%b q8=%h nq8=%h, required q1=%b q8=%h",
                         i, q1, nq1, q8, nq8, e.q1, e.q8);
            end
        end
    endtask

    // Enters with q1=1, q8=FF and c high; reset pulse with no clock edge.
    task automatic test_async_reset();
        step_t t[7] = '{
            '{A_RST,  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_REL,  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_NONE, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_FALL, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_RISE, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_FALL, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
            '{A_RISE, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C}
        };
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (q1 !== e.q1 || nq1 !== ~e.q1 || q8 !== e.q8 || nq8 !== ~e.q8) begin
                errors++;
                $display("FAIL async_reset[%0d]: q1=%b nq1=%b q8=%h nq8=%h, required q1=%b q8=%h",
                         i, q1, nq1, q8, nq8, e.q1, e.q8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_capture();
        test_enable_hold();
        test_set_clear();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dc_trigger_ff.md
Name: dc_trigger_ff

Overview:
- Edge-triggered D-type trigger ("dynamic" D flip-flop).
- Captures `d` on the rising edge of clock `c` and holds it on `q`, with complementary output `nq`.
- Basic storage cell used by edge-sensitive wrappers such as the RS edge trigger, e.g. master stage clocked by `s` with `d` tied to 1.
- Built as a master-slave pair of level-sensitive latches, with an asynchronous active-low reset and optional synchronous set/clear/enable.

Parameters:
- WIDTH, 1, number of independent trigger bits (all share `c` and `r_n`).
- RST_VAL, {WIDTH{1'b0}}, value loaded into `q` by reset; also the power-up value.

Ports:
- c  input  1  clock; state updates on rising edge.
- r_n  input  1  asynchronous reset, active-low.
- d  input  WIDTH  data captured on rising edge of `c`.
- en  input  1  load enable; when 0, `q` holds.
- sclr  input  1  synchronous clear; forces `q` to 0 at the edge.
- sset  input  1  synchronous set; forces `q` to all-ones at the edge.
- q  output  WIDTH  stored value.
- nq  output  WIDTH  bitwise complement of `q`, always.

Behaviour:
- Reset: while `r_n`=0, `q`=RST_VAL and `nq`=~RST_VAL immediately, independent of `c`.
  - Both master and slave latches are forced to RST_VAL.
  - Reset takes priority over every other input.
- Deassertion of `r_n`: the first rising edge of `c` strictly after deassertion is the first load. An edge coincident with deassertion is ignored, because reset still dominates.
- Power-up, without reset: `q`=RST_VAL (initial value 0 by default).
- At each rising edge of `c` with `r_n`=1, priority order:
  1. `sclr`=1 → `q`=0.
  2. else `sset`=1 → `q`=all-ones.
  3. else `en`=1 → `q`=`d`.
  4. else `q` unchanged.
- Simultaneous `sclr` and `sset`: clear wins. This matches RS convention here, where `r` dominates `s`.
- Latency: `q` reflects the selected next value one edge after sampling; zero-cycle combinational path from `r_n` to `q`/`nq` only.
- Between edges, `q` does not change for any `d`/`en`/`sclr`/`sset` activity. No transparency: changes to `d` while `c`=1 must not reach `q`.
- Falling edge of `c`: no effect on `q`. The master latch opens and tracks the next-value mux.
- Master-slave structure:
  - Master latch is transparent while `c`=0 and captures the next-value mux output.
  - Slave latch is transparent while `c`=1 and copies the master.
  - Net effect is identical to an ideal rising-edge flop.
- Reset asserted mid-operation, including while `c`=1: `q` goes to RST_VAL at once. The pending master value is discarded.
- Bit independence: each of the WIDTH bits behaves as a separate 1-bit trigger under the shared control signals.
- `nq` is always exactly ~`q`. Never X after reset.

Decomposition:
- No shared package needed. WIDTH and RST_VAL are local parameters of this block.
- One natural sub-module: `dc_latch`, a level-sensitive D latch.
  - Parameters: WIDTH, RST_VAL.
  - Ports: `g` (gate, transparent high), `r_n`, `d`, `q`.
  - Instantiated twice: master with `g`=~`c`, slave with `g`=`c`.
- The next-value mux (clear/set/enable/hold) lives in `dc_trigger_ff` ahead of the master.

Test Plan:
- Reset: hold `r_n`=0, toggle `c` with `d`=1 → `q`=0 and `nq`=1 throughout. Release `r_n`, first rising edge with `d`=1 → `q`=1, `nq`=0.
- Edge capture: `d`=1 before rising edge, `d`=0 while `c`=1 → `q`=1 until the next rising edge. Next edge with `d`=0 → `q`=0. Falling edges never change `q`.
- Enable hold: `q`=1, `en`=0, `d`=0, three rising edges → `q` stays 1. Set `en`=1, one edge → `q`=0.
- Sync set/clear priority: `sset`=1 and `sclr`=1 with `d`=1, `en`=1 → `q`=0 after the edge. `sset`=1 alone with `d`=0 → `q`=1 after the edge.
- Async reset mid-cycle: `q`=1, `c` held high, pulse `r_n` low for 2 ns → `q`=0 immediately, without any clock edge. It stays 0 until the next rising edge with `d`=1.
- WIDTH=8, RST_VAL=8'hA5: after reset `q`=A5 and `nq`=5A. Edge with `d`=3C, `en`=1 → `q`=3C and `nq`=C3.
